shift_add_mult: RTL
===================

SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 SHALL have port CLOCK  input  1  sole clock; all state updates on posedge.
REQ-002 SHALL have port RESET  input  1  synchronous, active-high reset; sampled on posedge CLOCK only.
REQ-003 SHALL have port LOAD  input  1  start request; sampled on posedge CLOCK.
REQ-004 SHALL have port inQ  input  16  multiplicand (quotient to reconstruct).
REQ-005 SHALL have port inB  input  8  multiplier (divisor).
REQ-006 SHALL have port inR  input  8  addend (remainder), added once to the product.
REQ-007 SHALL have port prod  output  24  result inQ*inB+inR, registered.
REQ-008 SHALL have port FLAG  output  3  status code, registered.
REQ-009 SHALL have port busy  output  1  high while in RUN, registered.

Function
REQ-010 SHALL implement states IDLE, RUN, DONE.
REQ-011 SHALL, in IDLE or DONE with LOAD=1, capture inQ, inB and inR into internal registers, clear the iteration counter, and enter RUN; the inputs SHALL NOT be sampled again until the next accept.
REQ-012 SHALL ignore LOAD while in RUN; captured operands SHALL stay unchanged.
REQ-013 SHALL, in RUN, process one multiplier bit per cycle, LSB first: if the bit is 1, add (multiplicand << i) into a 24-bit accumulator preloaded with inR; 8 iterations fixed, no early exit.
REQ-014 SHALL, on the 8th RUN edge, load the accumulator into prod, set FLAG=3'b010 and busy=0, and enter DONE; result visible 8 edges after the accepting edge.
REQ-015 SHALL hold prod and FLAG stable in DONE until the next accept or RESET.
REQ-016 SHALL drive FLAG=3'b001 and busy=1 on every RUN edge before completion; prod SHALL keep its previous value during RUN.
REQ-017 SHALL use unsigned arithmetic; 24-bit width is never exceeded (max 65535*255+255 = 24'hFF0000), so no overflow flag exists.
REQ-018 SHALL, on LOAD=1 in DONE, restart immediately (back-to-back operation) with FLAG=3'b001 on the next edge.
REQ-019 SHALL leave FLAG codes 3'b101-3'b111 unused; they are never driven.

Reset
REQ-020 SHALL, with RESET=1 at a posedge, set state=IDLE, prod=0, FLAG=3'b000, busy=0, counter=0, operand registers=0.
REQ-021 SHALL give RESET priority over LOAD; reset mid-RUN SHALL abort without updating prod.
REQ-022 SHALL produce no X on any output after the first reset edge.

Configuration
REQ-023 SHALL support macro SHIFT_ADD_MULT_SPCASE_EN.
REQ-024 With the macro defined: on accept, inB==0 SHALL give prod=inR, FLAG=3'b011; inB==1 SHALL give prod=inQ+inR, FLAG=3'b100; both enter DONE on the accepting edge with busy staying 0.
REQ-025 Without the macro: all multipliers SHALL take the 8-cycle RUN path, and codes 3'b011 and 3'b100 SHALL never appear.

Structure
REQ-026 SHALL place the state enum, the FLAG code constants (IDLE_F, BUSY_F, DONE_F, ZERO_F, ONE_F) and the width constants (QW=16, BW=8, PW=24) in shared package shift_add_mult_pkg.
REQ-027 SHALL be a single module with no sub-module: one registered state/datapath process plus combinational next-state logic.

Verification
REQ-028 RESET=1 for 1 edge, then idle -> prod=0, FLAG=000, busy=0; LOAD=0 holds this indefinitely.
REQ-029 inQ=6, inB=7, inR=0, LOAD=1 for 1 cycle -> busy=1 for 8 edges, then prod=42, FLAG=010.
REQ-030 inQ=16'hFFFF, inB=8'hFF, inR=8'hFF -> prod=24'hFF0000, FLAG=010; inQ=14, inB=17, inR=12 -> prod=250.
REQ-031 LOAD pulsed again at RUN edge 3 with inQ=1 -> ignored; result = first operands. LOAD held in DONE -> back-to-back restart.
REQ-032 RESET at RUN edge 4 -> next edge prod=0, FLAG=000, busy=0, state IDLE.
REQ-033 inB=0, inR=5: with macro -> prod=5, FLAG=011 one edge after accept; without macro -> prod=5, FLAG=010 after 8 edges.

Source files
------------

// File: rtl/shift_add_mult_pkg.sv
// rtl/shift_add_mult_pkg.sv - shared states, FLAG codes and widths for shift_add_mult
package shift_add_mult_pkg;

  localparam int QW = 16;
  localparam int BW = 8;
  localparam int PW = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [2:0] IDLE_F = 3'b000;
  localparam logic [2:0] BUSY_F = 3'b001;
  localparam logic [2:0] DONE_F = 3'b010;
  localparam logic [2:0] ZERO_F = 3'b011;
  localparam logic [2:0] ONE_F  = 3'b100;

endpackage

// File: rtl/shift_add_mult.sv
// rtl/shift_add_mult.sv - sequential shift-add multiplier computing inQ*inB+inR over 8 RUN cycles
// Optional macro SHIFT_ADD_MULT_SPCASE_EN: inB==0 / inB==1 complete on the accepting edge.
module shift_add_mult
  import shift_add_mult_pkg::*;
(
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic          LOAD,
  input  logic [QW-1:0] inQ,
  input  logic [BW-1:0] inB,
  input  logic [BW-1:0] inR,
  output logic [PW-1:0] prod,
  output logic [2:0]    FLAG,
  output logic          busy
);

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [QW-1:0] q_q, q_d;
  logic [BW-1:0] b_q, b_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] prod_q, prod_d;
  logic [2:0]    flag_q, flag_d;
  logic          busy_q, busy_d;
  logic [PW-1:0] addend;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    b_d     = b_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    flag_d  = flag_q;
    busy_d  = busy_q;
    addend  = b_q[cnt_q] ? (PW'(q_q) << cnt_q) : '0;

    case (state_q)
      IDLE, DONE: begin
        if (LOAD) begin
          q_d     = inQ;
          b_d     = inB;
          acc_d   = PW'(inR);
          cnt_d   = '0;
          state_d = RUN;
          flag_d  = BUSY_F;
          busy_d  = 1'b1;
`ifdef SHIFT_ADD_MULT_SPCASE_EN
          // Trivial multipliers bypass the iteration entirely.
          if (inB == BW'(0)) begin
            state_d = DONE;
            flag_d  = ZERO_F;
            busy_d  = 1'b0;
            prod_d  = PW'(inR);
          end else if (inB == BW'(1)) begin
            state_d = DONE;
            flag_d  = ONE_F;
            busy_d  = 1'b0;
            prod_d  = PW'(inQ) + PW'(inR);
          end
`endif
        end
      end
      RUN: begin
        acc_d = acc_q + addend;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          prod_d  = acc_q + addend;
          flag_d  = DONE_F;
          busy_d  = 1'b0;
          state_d = DONE;
        end else begin
          flag_d = BUSY_F;
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      flag_q  <= IDLE_F;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      flag_q  <= flag_d;
      busy_q  <= busy_d;
    end
  end

  assign prod = prod_q;
  assign FLAG = flag_q;
  assign busy = busy_q;

endmodule
